// File: rtl/sample_delay_pkg.sv
// Shared types and default widths for the sample delay-line controller.
package sample_delay_pkg;

    localparam int DEF_ADDRESS_WIDTH = 8;
    localparam int DEF_DATA_WIDTH    = 8;
    localparam int PIPE_STAGES       = 2;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sample_delay_ctrl_if.sv
// RAM-side bus between the delay controller and a two-port RAM with a registered read port.
interface sample_delay_ctrl_if #(
    parameter int ADDRESS_WIDTH = sample_delay_pkg::DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = sample_delay_pkg::DEF_DATA_WIDTH
);
    logic                     ram_wr;
    logic [ADDRESS_WIDTH-1:0] ram_wr_addr;
    logic [DATA_WIDTH-1:0]    ram_din;
    logic                     ram_rd;
    logic [ADDRESS_WIDTH-1:0] ram_rd_addr;
    logic [DATA_WIDTH-1:0]    ram_dout;

    modport master (
        output ram_wr, ram_wr_addr, ram_din, ram_rd, ram_rd_addr,
        input  ram_dout
    );

    modport slave (
        input  ram_wr, ram_wr_addr, ram_din, ram_rd, ram_rd_addr,
        output ram_dout
    );
endinterface

// File: rtl/sample_delay_ctrl.sv
// Programmable sample-delay line built around an external two-port RAM.
// Each accepted sample reappears exactly delay_q accepted samples later, 2 cycles after its read.
module sample_delay_ctrl
    import sample_delay_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [DATA_WIDTH-1:0]    din,
    input  logic [ADDRESS_WIDTH-1:0] delay,
    sample_delay_ctrl_if.master      ram,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic                     dout_valid,
    output logic                     filling
);

    state_t                   state, state_nxt;
    logic [ADDRESS_WIDTH-1:0] wptr;
    logic [ADDRESS_WIDTH-1:0] delay_q;
    logic [ADDRESS_WIDTH-1:0] fill_cnt;
    logic [PIPE_STAGES:1]     vld_pipe;   // [1]: read issued last cycle, [2]: dout valid
    logic                     byp_q;
    logic [DATA_WIDTH-1:0]    byp_data;

    logic delay_chg, bypass, issue, take;

    always_comb begin
        delay_chg = (delay != delay_q);
        bypass    = (delay_q == '0);
        // Zero delay never waits for the fill count: the sample goes straight through.
        issue     = (state == RUN) || (fill_cnt == delay_q) || bypass;
        take      = en && issue && !delay_chg;
        state_nxt = state;
        if (delay_chg)
            state_nxt = FILL;
        else if (take)
            state_nxt = RUN;
    end

    assign ram.ram_wr      = en;
    assign ram.ram_wr_addr = wptr;
    assign ram.ram_din     = din;
    // A same-address read during write returns stale data, so bypass skips the RAM.
    assign ram.ram_rd      = take && !bypass;
    assign ram.ram_rd_addr = wptr - delay_q;

    assign dout_valid = vld_pipe[2];
    assign filling    = (state == FILL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FILL;
            wptr     <= '0;
            delay_q  <= '0;
            fill_cnt <= '0;
            vld_pipe <= '0;
            byp_q    <= 1'b0;
            byp_data <= '0;
            dout     <= '0;
        end else begin
            state <= state_nxt;
            if (en)
                wptr <= wptr + 1'b1;

            // A sample written on the change cycle is fill sample 0 of the new delay.
            if (delay_chg) begin
                delay_q  <= delay;
                fill_cnt <= {{(ADDRESS_WIDTH-1){1'b0}}, en};
            end else if (en && state == FILL) begin
                fill_cnt <= fill_cnt + 1'b1;
            end

            vld_pipe[1] <= take;
            vld_pipe[2] <= vld_pipe[1] && !delay_chg;

            if (take) begin
                byp_q    <= bypass;
                byp_data <= din;
            end

            if (vld_pipe[1] && !delay_chg)
                dout <= byp_q ? byp_data : ram.ram_dout;
        end
    end

endmodule

// File: tb/tb_sample_delay_ctrl.sv
// Randomized bench for sample_delay_ctrl against an en-count based delay-line model.
module tb_sample_delay_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [DW-1:0] din;
    logic [AW-1:0] delay;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          filling;

    sample_delay_ctrl_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sample_delay_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .din        (din),
        .delay      (delay),
        .ram        (bus),
        .dout       (dout),
        .dout_valid (dout_valid),
        .filling    (filling)
    );

    always #5 clk = ~clk;

    // Two-port RAM with registered read
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.ram_wr) mem[bus.ram_wr_addr] <= bus.ram_din;
        if (bus.ram_rd) bus.ram_dout <= mem[bus.ram_rd_addr];
    end

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: history of all accepted samples, epoch = en count since reset/delay change
    logic [DW-1:0] hist [8192];
    int g;       // global accepted sample index
    int mw;      // write pointer since reset
    int dq;      // delay in force
    int cnt;     // accepted samples in this epoch
    bit fill;
    bit s1_v;    // read issued last cycle
    int s1_d;
    bit ex_dv;
    int ex_dout;

    task automatic model_reset();
        mw = 0; dq = 0; cnt = 0; fill = 1'b1;
        s1_v = 1'b0; s1_d = 0; ex_dv = 1'b0; ex_dout = 0;
    endtask

    task automatic cyc(input bit e, input int d, input int dl);
        bit chg, iss;
        int data;
        @(negedge clk);
        chk("dout_valid", dout_valid, ex_dv);
        chk("dout", dout, ex_dout);
        chk("filling", filling, fill);
        en = e; din = d[DW-1:0]; delay = dl[AW-1:0];
        #1;
        chg  = (dl != dq);
        iss  = e && !chg && (cnt >= dq);
        data = (dq == 0) ? d : int'(hist[g - dq]);
        chk("ram_wr", bus.ram_wr, e);
        chk("ram_wr_addr", bus.ram_wr_addr, mw % DEPTH);
        chk("ram_din", bus.ram_din, d);
        chk("ram_rd", bus.ram_rd, iss && dq != 0);
        if (iss && dq != 0)
            chk("ram_rd_addr", bus.ram_rd_addr, (mw - dq + DEPTH) % DEPTH);
        ex_dv = s1_v && !chg;
        if (ex_dv) ex_dout = s1_d;
        s1_v = iss;
        s1_d = data;
        if (chg) begin
            dq = dl; cnt = e ? 1 : 0; fill = 1'b1;
        end else if (e) begin
            cnt++;
        end
        if (iss) fill = 1'b0;
        if (e) begin
            hist[g] = d[DW-1:0]; g++; mw++;
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0; en = 1'b0;
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_filling", filling, 1);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; din = '0; delay = 4'd3;
        g = 0;
        model_reset();
        #1;
        chk("init_dout", dout, 0);
        chk("init_dout_valid", dout_valid, 0);
        chk("init_filling", filling, 1);
        chk("init_ram_rd", bus.ram_rd, 0);
        #20 rst_n = 1'b1;

        // delay 3, din 10,11,...
        for (int i = 0; i < 12; i++) cyc(1'b1, 10 + i, 3);
        // bypass
        for (int i = 0; i < 6; i++) cyc(1'b1, 5 + i, 0);
        // full-depth delay with wrap
        for (int i = 0; i < 40; i++) cyc(1'b1, 100 + i, 15);
        // gapped en at delay 2
        for (int i = 0; i < 24; i++) cyc(i % 3 == 0, 50 + i, 2);
        // RUN at delay 2 then change to 5 with en high
        for (int i = 0; i < 8; i++) cyc(1'b1, 150 + i, 2);
        for (int i = 0; i < 12; i++) cyc(1'b1, 170 + i, 5);
        for (int i = 0; i < 4; i++) cyc(1'b0, 0, 5);

        // randomized traffic with occasional delay changes
        begin
            int dl;
            dl = 5;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(39) == 0) dl = $urandom_range(15);
                cyc($urandom_range(3) != 0, $urandom_range(255), dl);
            end
        end

        // mid-stream reset, then the first scenario again
        for (int i = 0; i < 5; i++) cyc(1'b1, 200 + i, 3);
        async_reset();
        for (int i = 0; i < 12; i++) cyc(1'b1, 10 + i, 3);
        for (int i = 0; i < 3; i++) cyc(1'b0, 0, 3);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
